// File: rtl/rip_bp_pkg.sv
// Shared branch-predictor types: 2-bit saturating counter encoding, PHT scheduler
// FSM states and the counter update rule used by both predictor and PHT writer.
package rip_bp_pkg;

  typedef enum logic [1:0] {
    STRONGLY_UNTAKEN = 2'b00,
    WEAKLY_UNTAKEN   = 2'b01,
    WEAKLY_TAKEN     = 2'b10,
    STRONGLY_TAKEN   = 2'b11
  } two_bit_saturating_counter_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_e;

  function automatic two_bit_saturating_counter_t sat_update(
    input two_bit_saturating_counter_t counter,
    input logic                        actual
  );
    two_bit_saturating_counter_t res;
    res = counter;
    if (actual) begin
      if (counter != STRONGLY_TAKEN) res = two_bit_saturating_counter_t'(counter + 2'd1);
    end else begin
      if (counter != STRONGLY_UNTAKEN) res = two_bit_saturating_counter_t'(counter - 2'd1);
    end
    return res;
  endfunction

endpackage

// File: rtl/rip_bp_update_queue.sv
// Circular FIFO of pending PHT writes {index, next counter}, with a per-entry
// index compare so fetch can see lookups that hit a not-yet-written entry.
module rip_bp_update_queue
  import rip_bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        push,
  input  logic [ADDR_WIDTH-1:0]       push_index,
  input  two_bit_saturating_counter_t push_counter,
  input  logic                        pop,
  input  logic [ADDR_WIDTH-1:0]       lookup_index,
  output logic [ADDR_WIDTH-1:0]       head_index,
  output two_bit_saturating_counter_t head_counter,
  output logic                        full,
  output logic                        empty,
  output logic                        lookup_match
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]       index;
    two_bit_saturating_counter_t counter;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] offset;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      mem_d[tail_q] = '{index: push_index, counter: push_counter};
      tail_d        = tail_q + PTR_W'(1);
    end
    if (pop) head_d = head_q + PTR_W'(1);
    if (clr) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointers and count are control; the storage array is left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  assign head_index   = mem_q[head_q].index;
  assign head_counter = mem_q[head_q].counter;
  assign full         = (count_q == CNT_W'(DEPTH));
  assign empty        = (count_q == '0);

  // An entry is live when its distance from the head is below the count.
  always_comb begin
    lookup_match = 1'b0;
    offset       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - head_q;
      if (({1'b0, offset} < count_q) && (mem_q[i].index == lookup_index))
        lookup_match = 1'b1;
    end
  end

endmodule

// File: rtl/rip_bp_pht_scheduler.sv
// PHT write-port owner: walks the table with INIT_VALUE after reset/flush, then
// drains queued resolved-branch counter updates at one write per cycle.
module rip_bp_pht_scheduler
  import rip_bp_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 10,
  parameter int         QUEUE_DEPTH = 4,
  parameter logic [1:0] INIT_VALUE  = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_req,
  output logic                  busy,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic [ADDR_WIDTH-1:0] upd_index,
  input  logic [1:0]            upd_counter,
  input  logic                  upd_actual,
  input  logic                  wr_hold,
  output logic                  pht_we,
  output logic [ADDR_WIDTH-1:0] pht_waddr,
  output logic [1:0]            pht_wdata,
  input  logic [ADDR_WIDTH-1:0] lookup_index,
  output logic                  lookup_pending
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  pht_state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]       init_addr_q, init_addr_d;
  logic                        in_run;
  logic                        push, pop, q_clr;
  logic                        q_full, q_empty, q_match;
  logic [ADDR_WIDTH-1:0]       head_index;
  two_bit_saturating_counter_t head_counter;

  assign in_run = (state_q == ST_RUN);
  assign push   = upd_valid & upd_ready & ~flush_req;
  assign pop    = in_run & ~rst & ~q_empty & ~wr_hold;
  assign q_clr  = in_run & flush_req;

  rip_bp_update_queue #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .rst          (rst),
    .clr          (q_clr),
    .push         (push),
    .push_index   (upd_index),
    .push_counter (sat_update(two_bit_saturating_counter_t'(upd_counter), upd_actual)),
    .pop          (pop),
    .lookup_index (lookup_index),
    .head_index   (head_index),
    .head_counter (head_counter),
    .full         (q_full),
    .empty        (q_empty),
    .lookup_match (q_match)
  );

  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    case (state_q)
      ST_INIT: begin
        if (flush_req) begin
          init_addr_d = '0;
        end else begin
          init_addr_d = init_addr_q + 1'b1;
          if (init_addr_q == LAST_ADDR) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          state_d     = ST_INIT;
          init_addr_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
    end
  end

  // rst gates the outputs directly so the port is quiet for the whole reset window.
  always_comb begin
    busy           = 1'b1;
    upd_ready      = 1'b0;
    pht_we         = 1'b0;
    pht_waddr      = '0;
    pht_wdata      = INIT_VALUE;
    lookup_pending = 1'b0;
    if (!rst) begin
      if (in_run) begin
        busy           = 1'b0;
        upd_ready      = ~q_full;
        pht_we         = ~q_empty & ~wr_hold;
        pht_waddr      = head_index;
        pht_wdata      = head_counter;
        lookup_pending = q_match;
      end else begin
        pht_we    = 1'b1;
        pht_waddr = init_addr_q;
      end
    end
  end

endmodule

// File: tb/tb_rip_bp_pht_scheduler.sv
// Directed bench for rip_bp_pht_scheduler: init walk, counter rule, back-pressure,
// lookup hazard, flush and reset during the init walk.
module tb_rip_bp_pht_scheduler;

  localparam int         AW   = 6;
  localparam int         QD   = 4;
  localparam logic [1:0] INIT = 2'b01;
  localparam int         NENT = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, flush_req, busy;
  logic          upd_valid, upd_ready, upd_actual, wr_hold;
  logic [AW-1:0] upd_index, pht_waddr, lookup_index;
  logic [1:0]    upd_counter, pht_wdata;
  logic          pht_we, lookup_pending;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  rip_bp_pht_scheduler #(
    .ADDR_WIDTH  (AW),
    .QUEUE_DEPTH (QD),
    .INIT_VALUE  (INIT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_req      (flush_req),
    .busy           (busy),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_index      (upd_index),
    .upd_counter    (upd_counter),
    .upd_actual     (upd_actual),
    .wr_hold        (wr_hold),
    .pht_we         (pht_we),
    .pht_waddr      (pht_waddr),
    .pht_wdata      (pht_wdata),
    .lookup_index   (lookup_index),
    .lookup_pending (lookup_pending)
  );

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_req = 1'b0; upd_valid = 1'b0; upd_index = '0;
    upd_counter = 2'b00; upd_actual = 1'b0; wr_hold = 1'b0; lookup_index = '0;
    repeat (3) @(posedge clk);
    to_neg();
    total_cnt++;
    if ({pht_we, upd_ready, busy, lookup_pending} !== 4'b0010)
      $display("FAIL reset_ctrl we/rdy/busy/pend=%b want 0010", {pht_we, upd_ready, busy, lookup_pending});
    else pass_cnt++;
    total_cnt++;
    if ({pht_waddr, pht_wdata} !== {6'd0, 2'b01})
      $display("FAIL reset_addr_data addr=%0d data=%b want 0/01", pht_waddr, pht_wdata);
    else pass_cnt++;
    to_drive();
    rst = 1'b0;
    for (int k = 0; k < NENT; k++) begin
      to_neg();
      total_cnt++;
      if ({pht_we, busy, upd_ready, pht_waddr, pht_wdata} !== {1'b1, 1'b1, 1'b0, 6'(k), 2'b01})
        $display("FAIL init_walk k=%0d we=%b busy=%b rdy=%b addr=%0d data=%b want 1/1/0/%0d/01",
                 k, pht_we, busy, upd_ready, pht_waddr, pht_wdata, k);
      else pass_cnt++;
      to_drive();
    end
    to_neg();
    total_cnt++;
    if ({busy, upd_ready, pht_we} !== 3'b010)
      $display("FAIL init_done busy/rdy/we=%b want 010", {busy, upd_ready, pht_we});
    else pass_cnt++;
  endtask

  task automatic test_counter_rule();
    logic [1:0] ctr [4];
    logic       act [4];
    logic [1:0] exp [4];
    ctr = '{2'b11, 2'b00, 2'b01, 2'b10};
    act = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp = '{2'b11, 2'b00, 2'b10, 2'b01};
    for (int n = 0; n < 4; n++) begin
      to_drive();
      upd_valid = 1'b1; upd_index = 6'(5 + n); upd_counter = ctr[n]; upd_actual = act[n];
      to_neg();
      total_cnt++;
      if (upd_ready !== 1'b1) $display("FAIL ctr_ready n=%0d rdy=%b want 1", n, upd_ready);
      else pass_cnt++;
      to_drive();
      upd_valid = 1'b0;
      to_neg();
      total_cnt++;
      if ({pht_we, pht_waddr, pht_wdata} !== {1'b1, 6'(5 + n), exp[n]})
        $display("FAIL ctr_write n=%0d we=%b addr=%0d data=%b want 1/%0d/%b",
                 n, pht_we, pht_waddr, pht_wdata, 5 + n, exp[n]);
      else pass_cnt++;
    end
    to_drive();
    to_neg();
    total_cnt++;
    if (pht_we !== 1'b0) $display("FAIL ctr_idle we=%b want 0", pht_we);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp [4];
    exp = '{2'b00, 2'b10, 2'b00, 2'b10};
    to_drive();
    wr_hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      upd_valid = 1'b1; upd_index = 6'(1 + n); upd_counter = 2'b01; upd_actual = n[0];
      to_neg();
      total_cnt++;
      if ({upd_ready, pht_we} !== {(n < 4), 1'b0})
        $display("FAIL bp_fill n=%0d rdy=%b we=%b want %b/0", n, upd_ready, pht_we, (n < 4));
      else pass_cnt++;
      to_drive();
    end
    upd_valid = 1'b0; wr_hold = 1'b0;
    for (int d = 0; d < 4; d++) begin
      to_neg();
      total_cnt++;
      if ({pht_we, pht_waddr, pht_wdata, upd_ready} !== {1'b1, 6'(1 + d), exp[d], (d != 0)})
        $display("FAIL bp_drain d=%0d we=%b addr=%0d data=%b rdy=%b want 1/%0d/%b/%b",
                 d, pht_we, pht_waddr, pht_wdata, upd_ready, 1 + d, exp[d], (d != 0));
      else pass_cnt++;
      to_drive();
    end
    to_neg();
    total_cnt++;
    if ({pht_we, upd_ready} !== 2'b01) $display("FAIL bp_empty we/rdy=%b want 01", {pht_we, upd_ready});
    else pass_cnt++;
  endtask

  task automatic test_hazard();
    to_drive();
    lookup_index = 6'h3A; wr_hold = 1'b1;
    upd_valid = 1'b1; upd_index = 6'h3A; upd_counter = 2'b10; upd_actual = 1'b1;
    to_neg();
    total_cnt++;
    if (lookup_pending !== 1'b0) $display("FAIL hz_before pend=%b want 0", lookup_pending);
    else pass_cnt++;
    to_drive();
    upd_valid = 1'b0;
    to_neg();
    total_cnt++;
    if (lookup_pending !== 1'b1) $display("FAIL hz_queued pend=%b want 1", lookup_pending);
    else pass_cnt++;
    #1 lookup_index = 6'h15;
    #1;
    total_cnt++;
    if (lookup_pending !== 1'b0) $display("FAIL hz_other_idx pend=%b want 0", lookup_pending);
    else pass_cnt++;
    lookup_index = 6'h3A;
    to_drive();
    wr_hold = 1'b0;
    to_neg();
    total_cnt++;
    if ({pht_we, pht_waddr, pht_wdata, lookup_pending} !== {1'b1, 6'h3A, 2'b11, 1'b1})
      $display("FAIL hz_write we=%b addr=%0h data=%b pend=%b want 1/3a/11/1",
               pht_we, pht_waddr, pht_wdata, lookup_pending);
    else pass_cnt++;
    to_drive();
    to_neg();
    total_cnt++;
    if ({lookup_pending, pht_we} !== 2'b00) $display("FAIL hz_popped pend/we=%b want 00", {lookup_pending, pht_we});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    to_drive();
    wr_hold = 1'b1; lookup_index = 6'h11;
    for (int n = 0; n < 3; n++) begin
      upd_valid = 1'b1; upd_index = 6'(6'h11 + n); upd_counter = 2'b10; upd_actual = 1'b1;
      to_drive();
    end
    upd_index = 6'h20; flush_req = 1'b1;
    to_neg();
    total_cnt++;
    if ({busy, lookup_pending, upd_ready, pht_we} !== 4'b0110)
      $display("FAIL fl_pre busy/pend/rdy/we=%b want 0110", {busy, lookup_pending, upd_ready, pht_we});
    else pass_cnt++;
    to_drive();
    flush_req = 1'b0; upd_valid = 1'b0; wr_hold = 1'b0;
    to_neg();
    total_cnt++;
    if ({busy, pht_we, pht_waddr, pht_wdata, upd_ready, lookup_pending} !== {1'b1, 1'b1, 6'd0, 2'b01, 1'b0, 1'b0})
      $display("FAIL fl_init busy=%b we=%b addr=%0d data=%b rdy=%b pend=%b want 1/1/0/01/0/0",
               busy, pht_we, pht_waddr, pht_wdata, upd_ready, lookup_pending);
    else pass_cnt++;
    for (int k = 1; k < NENT; k++) begin
      to_drive();
      to_neg();
      total_cnt++;
      if ({pht_we, pht_waddr, pht_wdata} !== {1'b1, 6'(k), 2'b01})
        $display("FAIL fl_walk k=%0d we=%b addr=%0d data=%b want 1/%0d/01", k, pht_we, pht_waddr, pht_wdata, k);
      else pass_cnt++;
    end
    for (int c = 0; c < 2; c++) begin
      to_drive();
      to_neg();
      total_cnt++;
      if ({busy, pht_we, lookup_pending} !== 3'b000)
        $display("FAIL fl_discarded c=%0d busy/we/pend=%b want 000", c, {busy, pht_we, lookup_pending});
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_init();
    to_drive();
    flush_req = 1'b1;
    to_drive();
    flush_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      to_neg();
      total_cnt++;
      if ({pht_we, pht_waddr} !== {1'b1, 6'(k)})
        $display("FAIL mid_walk k=%0d we=%b addr=%0d want 1/%0d", k, pht_we, pht_waddr, k);
      else pass_cnt++;
      if (k < 7) to_drive();
    end
    to_drive();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      to_neg();
      total_cnt++;
      if ({pht_we, busy, upd_ready, pht_waddr, pht_wdata} !== {1'b0, 1'b1, 1'b0, 6'd0, 2'b01})
        $display("FAIL mid_rst c=%0d we=%b busy=%b rdy=%b addr=%0d data=%b want 0/1/0/0/01",
                 c, pht_we, busy, upd_ready, pht_waddr, pht_wdata);
      else pass_cnt++;
      to_drive();
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      to_neg();
      total_cnt++;
      if ({pht_we, pht_waddr} !== {1'b1, 6'(k)})
        $display("FAIL mid_restart k=%0d we=%b addr=%0d want 1/%0d", k, pht_we, pht_waddr, k);
      else pass_cnt++;
      to_drive();
    end
    flush_req = 1'b1;
    to_drive();
    flush_req = 1'b0;
    to_neg();
    total_cnt++;
    if ({pht_we, busy, pht_waddr} !== {1'b1, 1'b1, 6'd0})
      $display("FAIL init_flush we=%b busy=%b addr=%0d want 1/1/0", pht_we, busy, pht_waddr);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_counter_rule();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_reset_mid_init();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
